// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline issue/hazard controller:
// opcode boundaries, opcode class helpers, forwarding encodings, tracking records.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned REG_W = 4;
    localparam int unsigned FWD_W = 2;

    localparam logic [OP_W-1:0] OP_RS12_LAST = 4'b0101;  // last opcode reading rs1+rs2 in the low range
    localparam logic [OP_W-1:0] OP_RS2_FIRST = 4'b0110;
    localparam logic [OP_W-1:0] OP_WR_LAST   = 4'b1010;  // 0000..1010 all write rd
    localparam logic [OP_W-1:0] OP_BEQ       = 4'b1011;
    localparam logic [OP_W-1:0] OP_JMP       = 4'b1100;
    localparam logic [OP_W-1:0] OP_MRDL      = 4'b1101;
    localparam logic [OP_W-1:0] OP_MRDH      = 4'b1110;
    localparam logic [OP_W-1:0] OP_MST       = 4'b1111;

    localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_W-1:0] FWD_E  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_M  = 2'b10;

    typedef enum logic {
        MULT_IDLE = 1'b0,
        MULT_BUSY = 1'b1
    } mult_state_t;

    // Execute-stage record; br/wr are already qualified by "slot holds an instruction".
    typedef struct packed {
        logic             br;
        logic             wr;
        logic [REG_W-1:0] rd;
    } e_trk_t;

    // Memory-stage record: only the write-back destination matters there.
    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] rd;
    } m_trk_t;

    function automatic logic is_mst(input logic [OP_W-1:0] op);
        return op == OP_MST;
    endfunction

    function automatic logic is_mrd(input logic [OP_W-1:0] op);
        return (op == OP_MRDL) || (op == OP_MRDH);
    endfunction

    function automatic logic is_wr(input logic [OP_W-1:0] op);
        return (op <= OP_WR_LAST) || is_mrd(op);
    endfunction

    function automatic logic is_br(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_JMP);
    endfunction

    function automatic logic uses_rs1(input logic [OP_W-1:0] op);
        return (op <= OP_RS12_LAST) || (op == OP_JMP) || (op == OP_MST);
    endfunction

    function automatic logic uses_rs2(input logic [OP_W-1:0] op);
        return uses_rs1(op) || ((op >= OP_RS2_FIRST) && (op <= OP_WR_LAST));
    endfunction

    // True when a used source would read a register still being produced in E or M.
    function automatic logic src_pending(input logic used, input logic [REG_W-1:0] rs,
                                         input e_trk_t e, input m_trk_t m);
        return used && ((e.wr && (e.rd == rs)) || (m.wr && (m.rd == rs)));
    endfunction

    // Operand select: youngest producer (E) wins over M.
    function automatic logic [FWD_W-1:0] fwd_sel(input logic used, input logic [REG_W-1:0] rs,
                                                 input e_trk_t e, input m_trk_t m);
        if (used && e.wr && (e.rd == rs)) return FWD_E;
        if (used && m.wr && (m.rd == rs)) return FWD_M;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bus between the datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_op;
    logic [3:0]       id_rd;
    logic [3:0]       id_rs1;
    logic [3:0]       id_rs2;
    logic             ex_br_taken;
    logic             id_ready;
    logic             issue;
    logic             stall;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mult_start;
    logic             mult_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_op, id_rd, id_rs1, id_rs2, ex_br_taken,
        input  id_ready, issue, stall, flush, fwd_a, fwd_b, mult_start, mult_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_op, id_rd, id_rs1, id_rs2, ex_br_taken,
        output id_ready, issue, stall, flush, fwd_a, fwd_b, mult_start, mult_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_mult_seq.sv
// Multiplier sequencer: IDLE/BUSY FSM with latency counter; start is a one-cycle pulse.
module pipe_hazard_ctrl_mult_seq
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_req,
    output logic start,
    output logic busy
);

    localparam int unsigned LAT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    mult_state_t      state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;

    // State, counter and start pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MULT_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    // Next-state: launch from IDLE, count down the remaining busy cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        case (state_q)
            MULT_IDLE: begin
                if (start_req) begin
                    state_d = MULT_BUSY;
                    cnt_d   = LAT_W'(MULT_LAT - 1);
                    start_d = 1'b1;
                end
            end
            MULT_BUSY: begin
                if (cnt_q == '0) state_d = MULT_IDLE;
                else             cnt_d   = cnt_q - LAT_W'(1);
            end
            default: state_d = MULT_IDLE;
        endcase
    end

    assign start = start_q;
    assign busy  = (state_q == MULT_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue/hazard controller for the 3-stage D/E/M pipeline.
// Optional feature: define PIPE_FWD_EN to resolve RAW hazards by forwarding
// instead of stalling.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    e_trk_t           e_q;
    m_trk_t           m_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             mult_start, mult_busy;
    logic             flush_c, stall_c, issue_c, mult_haz_c, raw_haz_c;
    logic [FWD_W-1:0] fwd_a_c, fwd_b_c;
    logic             use1_c, use2_c;

    // Hazard detection, forwarding selects and issue decision.
    always_comb begin
        use1_c     = bus.id_valid && uses_rs1(bus.id_op);
        use2_c     = bus.id_valid && uses_rs2(bus.id_op);
        flush_c    = e_q.br && bus.ex_br_taken;
        mult_haz_c = bus.id_valid && (is_mst(bus.id_op) || is_mrd(bus.id_op)) &&
                     (mult_busy || mult_start);
        raw_haz_c  = 1'b0;
        fwd_a_c    = FWD_RF;
        fwd_b_c    = FWD_RF;
`ifdef PIPE_FWD_EN
        fwd_a_c    = fwd_sel(use1_c, bus.id_rs1, e_q, m_q);
        fwd_b_c    = fwd_sel(use2_c, bus.id_rs2, e_q, m_q);
`else
        raw_haz_c  = src_pending(use1_c, bus.id_rs1, e_q, m_q) ||
                     src_pending(use2_c, bus.id_rs2, e_q, m_q);
`endif
        stall_c    = !flush_c && (mult_haz_c || raw_haz_c);
        issue_c    = reset && bus.id_valid && !stall_c && !flush_c;
    end

    // E/M destination tracking: bubble unless decode issues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            e_q.br <= issue_c && is_br(bus.id_op);
            e_q.wr <= issue_c && is_wr(bus.id_op);
            e_q.rd <= issue_c ? bus.id_rd : '0;
            m_q.wr <= e_q.wr;
            m_q.rd <= e_q.rd;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               stall_cnt_q <= '0;
        else if (stall_c && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    pipe_hazard_ctrl_mult_seq #(
        .MULT_LAT (MULT_LAT)
    ) u_mult_seq (
        .clk       (clk),
        .reset     (reset),
        .start_req (issue_c && is_mst(bus.id_op)),
        .start     (mult_start),
        .busy      (mult_busy)
    );

    assign bus.flush      = flush_c;
    assign bus.stall      = stall_c;
    assign bus.issue      = issue_c;
    assign bus.id_ready   = reset && !stall_c;
    assign bus.fwd_a      = fwd_a_c;
    assign bus.fwd_b      = fwd_b_c;
    assign bus.mult_start = mult_start;
    assign bus.mult_busy  = mult_busy;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then
// randomized decode traffic checked every cycle against a timeline model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MULT_LAT = 4;
    localparam int unsigned CNT_W    = 4;

    logic clk;
    logic reset;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: issue history timeline ----------------
    typedef struct { int cyc; logic [3:0] op; logic [3:0] rd; } iss_t;
    iss_t hist[$];
    int   now;
    int   last_mst;
    int   exp_cnt;

    function automatic bit op_wr(input logic [3:0] op);
        return op inside {[4'd0:4'd10], 4'd13, 4'd14};
    endfunction
    function automatic bit op_br(input logic [3:0] op);
        return op inside {4'd11, 4'd12};
    endfunction
    function automatic bit op_src1(input logic [3:0] op);
        return op inside {[4'd0:4'd5], 4'd12, 4'd15};
    endfunction
    function automatic bit op_src2(input logic [3:0] op);
        return op inside {[4'd0:4'd10], 4'd12, 4'd15};
    endfunction

    // Instruction issued 'age' cycles ago (1 -> now in E, 2 -> now in M).
    function automatic bit find(input int age, output logic [3:0] op, output logic [3:0] rd);
        op = '0; rd = '0;
        foreach (hist[i]) if (hist[i].cyc == now - age) begin
            op = hist[i].op; rd = hist[i].rd; return 1'b1;
        end
        return 1'b0;
    endfunction

    // Per-cycle compare against the model, then advance the model by one cycle.
    always @(negedge clk) begin
        logic [3:0] eop, erd, mop, mrd;
        bit ef, mf, ewr, mwr, u1, u2, e1, m1, e2, m2;
        bit x_flush, x_busy, x_start, x_mhaz, x_raw, x_stall, x_issue;
        int age, xa, xb;
        if (!reset) begin
            chk("rst_issue", 32'(bus.issue), 0);
            chk("rst_stall", 32'(bus.stall), 0);
            chk("rst_flush", 32'(bus.flush), 0);
            chk("rst_ready", 32'(bus.id_ready), 0);
            chk("rst_fwd", 32'({bus.fwd_a, bus.fwd_b}), 0);
            chk("rst_mult", 32'({bus.mult_start, bus.mult_busy}), 0);
            chk("rst_cnt", 32'(bus.stall_cnt), 0);
            now = 0; hist.delete(); last_mst = -100; exp_cnt = 0;
        end else begin
            ef  = find(1, eop, erd);
            mf  = find(2, mop, mrd);
            ewr = ef && op_wr(eop);
            mwr = mf && op_wr(mop);
            x_flush = ef && op_br(eop) && bus.ex_br_taken;
            age     = now - last_mst;
            x_busy  = (age >= 1) && (age <= int'(MULT_LAT));
            x_start = (age == 1);
            x_mhaz  = bus.id_valid && (bus.id_op inside {4'd13, 4'd14, 4'd15}) && x_busy;
            u1 = bus.id_valid && op_src1(bus.id_op);
            u2 = bus.id_valid && op_src2(bus.id_op);
            e1 = u1 && ewr && (erd == bus.id_rs1);
            m1 = u1 && mwr && (mrd == bus.id_rs1);
            e2 = u2 && ewr && (erd == bus.id_rs2);
            m2 = u2 && mwr && (mrd == bus.id_rs2);
`ifdef PIPE_FWD_EN
            x_raw = 1'b0;
            xa = e1 ? 1 : (m1 ? 2 : 0);
            xb = e2 ? 1 : (m2 ? 2 : 0);
`else
            x_raw = e1 || m1 || e2 || m2;
            xa = 0;
            xb = 0;
`endif
            x_stall = !x_flush && (x_mhaz || x_raw);
            x_issue = bus.id_valid && !x_stall && !x_flush;
            chk("flush", 32'(bus.flush), 32'(x_flush));
            chk("stall", 32'(bus.stall), 32'(x_stall));
            chk("issue", 32'(bus.issue), 32'(x_issue));
            chk("id_ready", 32'(bus.id_ready), 32'(!x_stall));
            chk("fwd_a", 32'(bus.fwd_a), 32'(xa));
            chk("fwd_b", 32'(bus.fwd_b), 32'(xb));
            chk("mult_start", 32'(bus.mult_start), 32'(x_start));
            chk("mult_busy", 32'(bus.mult_busy), 32'(x_busy));
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(exp_cnt));
            if (x_stall && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            if (x_issue) begin
                hist.push_back('{now, bus.id_op, bus.id_rd});
                if (bus.id_op == 4'd15) last_mst = now;
            end
            while (hist.size() > 2) void'(hist.pop_front());
            now++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input bit tk);
        @(posedge clk); #1;
        bus.id_valid = v; bus.id_op = op; bus.id_rd = rd;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.ex_br_taken = tk;
    endtask

    task automatic smp;
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(0, 4'd0, 4'd0, 4'd0, 4'd0, 0);
    endtask

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, BEQ = 4'b1011, JMP = 4'b1100;
    localparam logic [3:0] MRD = 4'b1101, MST = 4'b1111;

    initial begin
        int cnt_before;
        bit held;
        logic [3:0] r_op, r_rd, r_rs1, r_rs2;
        bit r_v;
        reset = 1'b0;
        bus.id_valid = 0; bus.id_op = '0; bus.id_rd = '0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_br_taken = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Back-to-back dependent ADDs.
        drv(1, ADD, 4'd1, 4'd2, 4'd3, 0); smp;
        chk("t2_first_issue", 32'(bus.issue), 1);
        drv(1, ADD, 4'd2, 4'd1, 4'd1, 0); smp;
`ifdef PIPE_FWD_EN
        chk("t2_fwd_a", 32'(bus.fwd_a), 1);
        chk("t2_fwd_b", 32'(bus.fwd_b), 1);
        chk("t2_no_stall", 32'(bus.stall), 0);
`else
        chk("t2_stall1", 32'(bus.stall), 1);
        drv(1, ADD, 4'd2, 4'd1, 4'd1, 0); smp;
        chk("t2_stall2", 32'(bus.stall), 1);
        drv(1, ADD, 4'd2, 4'd1, 4'd1, 0); smp;
        chk("t2_release", 32'(bus.issue), 1);
        chk("t2_cnt", 32'(bus.stall_cnt), 2);
`endif
        idle(3);

        // Producer two ahead (M), then producers in both E and M.
        drv(1, ADD, 4'd1, 4'd2, 4'd3, 0);
        drv(1, BEQ, 4'd0, 4'd0, 4'd0, 0);
        drv(1, SUB, 4'd3, 4'd1, 4'd4, 0); smp;
`ifdef PIPE_FWD_EN
        chk("t3_m_fwd_a", 32'(bus.fwd_a), 2);
        chk("t3_m_fwd_b", 32'(bus.fwd_b), 0);
`else
        chk("t3_m_stall", 32'(bus.stall), 1);
        drv(1, SUB, 4'd3, 4'd1, 4'd4, 0); smp;
        chk("t3_m_issue", 32'(bus.issue), 1);
`endif
        idle(3);
        drv(1, ADD, 4'd1, 4'd2, 4'd3, 0);
        drv(1, ADD, 4'd1, 4'd5, 4'd6, 0);
        drv(1, SUB, 4'd3, 4'd1, 4'd4, 0); smp;
`ifdef PIPE_FWD_EN
        chk("t3_em_fwd_a", 32'(bus.fwd_a), 1);
`else
        chk("t3_em_stall1", 32'(bus.stall), 1);
        drv(1, SUB, 4'd3, 4'd1, 4'd4, 0); smp;
        chk("t3_em_stall2", 32'(bus.stall), 1);
        drv(1, SUB, 4'd3, 4'd1, 4'd4, 0); smp;
        chk("t3_em_issue", 32'(bus.issue), 1);
`endif
        idle(3);

        // Taken branch in E kills decode.
        drv(1, JMP, 4'd0, 4'd7, 4'd8, 0);
        drv(1, ADD, 4'd4, 4'd5, 4'd6, 1); smp;
        chk("t5_flush", 32'(bus.flush), 1);
        chk("t5_issue", 32'(bus.issue), 0);
        chk("t5_stall", 32'(bus.stall), 0);
        idle(3);

        // MST then MRD.
        drv(1, MST, 4'd0, 4'd12, 4'd13, 0); smp;
        chk("t4_mst_issue", 32'(bus.issue), 1);
        chk("t4_no_start_yet", 32'(bus.mult_start), 0);
        drv(1, MRD, 4'd2, 4'd0, 4'd0, 0); smp;
        chk("t4_start", 32'(bus.mult_start), 1);
        chk("t4_busy", 32'(bus.mult_busy), 1);
        chk("t4_stall", 32'(bus.stall), 1);
        for (int i = 0; i < 3; i++) begin
            drv(1, MRD, 4'd2, 4'd0, 4'd0, 0); smp;
            chk("t4_pulse_once", 32'(bus.mult_start), 0);
            chk("t4_busy_hold", 32'(bus.mult_busy), 1);
            chk("t4_stall_hold", 32'(bus.stall), 1);
        end
        drv(1, MRD, 4'd2, 4'd0, 4'd0, 0); smp;
        chk("t4_busy_fall", 32'(bus.mult_busy), 0);
        chk("t4_mrd_issue", 32'(bus.issue), 1);
        idle(3);

        // Flush coinciding with a multiplier stall.
        drv(1, MST, 4'd0, 4'd12, 4'd13, 0);
        drv(1, BEQ, 4'd0, 4'd7, 4'd8, 0);
        drv(1, MRD, 4'd2, 4'd0, 4'd0, 1); smp;
        chk("t6_flush", 32'(bus.flush), 1);
        chk("t6_stall", 32'(bus.stall), 0);
        cnt_before = int'(bus.stall_cnt);
        idle(1); smp;
        chk("t6_cnt_same", 32'(bus.stall_cnt), 32'(cnt_before));
        idle(6);

        // Reset mid-BUSY.
        drv(1, MST, 4'd0, 4'd12, 4'd13, 0);
        drv(0, 4'd0, 4'd0, 4'd0, 4'd0, 0); smp;
        chk("t1_busy_before", 32'(bus.mult_busy), 1);
        drv(1, MST, 4'd0, 4'd12, 4'd13, 0); #3;
        reset = 1'b0; #1;
        chk("t1_busy", 32'(bus.mult_busy), 0);
        chk("t1_start", 32'(bus.mult_start), 0);
        chk("t1_cnt", 32'(bus.stall_cnt), 0);
        chk("t1_issue", 32'(bus.issue), 0);
        chk("t1_ready", 32'(bus.id_ready), 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;

        // Randomized traffic on a small register file to provoke hazards.
        held = 0;
        r_v = 0; r_op = '0; r_rd = '0; r_rs1 = '0; r_rs2 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!held) begin
                r_v   = ($urandom_range(0, 9) != 0);
                r_op  = 4'($urandom_range(0, 15));
                r_rd  = 4'($urandom_range(0, 3));
                r_rs1 = 4'($urandom_range(0, 3));
                r_rs2 = 4'($urandom_range(0, 3));
            end
            drv(r_v, r_op, r_rd, r_rs1, r_rs2, bit'($urandom_range(0, 1)));
            @(negedge clk);
            held = bus.stall;
            if (i == 1500) begin
                #2 reset = 1'b0;
                @(posedge clk); @(posedge clk); #1 reset = 1'b1;
                held = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
